// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small power-of-two FIFO; back-to-back frames
// are sent with no idle gap while bytes remain queued.
module uart_tx_fifo #(
   parameter int CLK_PER_BIT = 56,
   parameter int FIFO_AW     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pi_flag,
   input  logic [7:0] pi_data,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       tx_ovf
);

   localparam int                DEPTH     = 2 ** FIFO_AW;
   localparam int                CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0]     BAUD_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0]     BAUD_ONE  = CW'(1);
   localparam logic [FIFO_AW:0]  PTR_ONE   = (FIFO_AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic             empty, push, pop, baud_last;
   logic [7:0]       rd_data, shreg;
   logic [CW-1:0]    baud_cnt;
   logic [2:0]       bit_cnt;

   // NOTE: every signal gets a value on every path here, so no latch can be inferred.
   always_comb begin
      baud_last  = (baud_cnt == BAUD_LAST);
      pop        = ~empty & ((state == IDLE) | ((state == STOP) & baud_last));
      push       = pi_flag & (~fifo_full | pop);
      wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
      rd_data    = mem[rd_ptr[FIFO_AW-1:0]];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         empty     <= 1'b1;
         fifo_full <= 1'b0;
         tx_ovf    <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         empty     <= (wr_ptr_nxt == rd_ptr_nxt);
         fifo_full <= (wr_ptr_nxt[FIFO_AW] != rd_ptr_nxt[FIFO_AW]) &&
                      (wr_ptr_nxt[FIFO_AW-1:0] == rd_ptr_nxt[FIFO_AW-1:0]);
         tx_ovf    <= pi_flag & fifo_full & ~pop;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= pi_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         shreg    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg    <= rd_data;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end else begin
                  busy <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  // Chain straight into the next start bit when more bytes wait.
                  if (pop) begin
                     shreg <= rd_data;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a serial monitor decodes frames and
// compares them against a queue of expected bytes filled as pushes are driven.
module tb_uart_tx_fifo;

   localparam int C     = 56;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pi_flag = 1'b0;
   logic [7:0] pi_data = 8'h00;
   logic       tx, busy, fifo_full, tx_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q [$];
   logic [7:0] burst [4];

   typedef struct {
      logic [7:0] data;
      logic       accept;
      logic       exp_full;
      logic       exp_ovf;
      logic       exp_busy;
   } vec_t;
   vec_t vec [10];

   uart_tx_fifo #(.CLK_PER_BIT(C), .FIFO_AW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .pi_flag   (pi_flag),
      .pi_data   (pi_data),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .tx_ovf    (tx_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Serial monitor: samples mid-bit and scores each completed frame.
   logic       m_active = 1'b0;
   int         m_cnt = 0;
   int         m_k = 0;
   logic [7:0] m_byte = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (tx == 1'b0) begin
            m_active = 1'b1;
            m_cnt    = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt == C / 2) begin
            check("rx_start_bit", tx, 1'b0);
         end else if (m_cnt > C / 2 && (m_cnt - C / 2) % C == 0) begin
            m_k = (m_cnt - C / 2) / C;
            if (m_k <= 8) begin
               m_byte[m_k-1] = tx;
            end else begin
               check("rx_stop_bit", tx, 1'b1);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL rx_unexpected_frame: got %0h, expected no frame", m_byte);
               end else begin
                  check("rx_byte", m_byte, exp_q.pop_front());
               end
               m_active = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle(input int limit);
      int t = 0;
      while (busy !== 1'b0 && t < limit) begin
         @(posedge clk); #1;
         t++;
      end
      check("idle_within_bound", busy, 1'b0);
      repeat (C) @(posedge clk);
      #1;
   endtask

   // Pushes burst[0..n-1] on consecutive cycles and checks tx and busy every cycle.
   task automatic send_and_check(input int n);
      int   bad_tx   = 0;
      int   bad_busy = 0;
      int   s, f, b;
      logic e;
      for (int j = 0; j <= n * FRAME; j++) begin
         @(negedge clk);
         if (j < n) begin
            pi_flag = 1'b1;
            pi_data = burst[j];
            exp_q.push_back(burst[j]);
         end else begin
            pi_flag = 1'b0;
         end
         @(posedge clk); #1;
         if (j == 0) begin
            check("tx_high_after_write_edge", tx, 1'b1);
            check("busy_low_after_write_edge", busy, 1'b0);
         end else begin
            s = j - 1;
            f = s / FRAME;
            b = (s % FRAME) / C;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : burst[f][b-1];
            if (tx !== e) bad_tx++;
            if (busy !== 1'b1) bad_busy++;
         end
      end
      check("line_waveform_errors", bad_tx, 0);
      check("busy_span_errors", bad_busy, 0);
      @(posedge clk); #1;
      check("tx_idle_after_frames", tx, 1'b1);
      check("busy_low_after_frames", busy, 1'b0);
   endtask

   initial begin
      int bad;

      vec[0] = '{8'hA0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[1] = '{8'hA1, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[2] = '{8'hA2, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[3] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[4] = '{8'hA4, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[6] = '{8'hA6, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[7] = '{8'hA7, 1'b1, 1'b0, 1'b0, 1'b1};
      vec[8] = '{8'hA8, 1'b1, 1'b1, 1'b0, 1'b1};
      vec[9] = '{8'hA9, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset for 100 ns, then 10 us of silence.
      #50;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_fifo_full", fifo_full, 1'b0);
      check("rst_tx_ovf", tx_ovf, 1'b0);
      #52;
      rst = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0 || tx_ovf !== 1'b0) bad++;
      end
      check("idle_after_reset_violations", bad, 0);

      // Single byte, then four back-to-back bytes.
      burst[0] = 8'h55;
      send_and_check(1);
      wait_idle(2 * FRAME);
      burst[0] = 8'h12;
      burst[1] = 8'h34;
      burst[2] = 8'h56;
      burst[3] = 8'h78;
      send_and_check(4);
      wait_idle(2 * FRAME);

      // Overfill: ten pushes on consecutive cycles, the tenth is dropped.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pi_flag = 1'b1;
         pi_data = vec[i].data;
         if (vec[i].accept) exp_q.push_back(vec[i].data);
         @(posedge clk); #1;
         check($sformatf("ovfl_full_%0d", i), fifo_full, vec[i].exp_full);
         check($sformatf("ovfl_ovf_%0d", i), tx_ovf, vec[i].exp_ovf);
         check($sformatf("ovfl_busy_%0d", i), busy, vec[i].exp_busy);
      end
      @(negedge clk);
      pi_flag = 1'b0;
      @(posedge clk); #1;
      check("ovf_single_pulse", tx_ovf, 1'b0);
      check("full_held_after_drop", fifo_full, 1'b1);
      wait_idle(12 * FRAME);

      // Full FIFO, push lands on the last STOP cycle of the first frame.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         pi_flag = 1'b1;
         pi_data = 8'(8'hB0 + i);
         exp_q.push_back(8'(8'hB0 + i));
         @(posedge clk);
      end
      @(negedge clk);
      pi_flag = 1'b0;
      repeat (FRAME - 8) @(posedge clk);
      #1;
      check("full_before_stop_pop", fifo_full, 1'b1);
      check("tx_in_stop_bit", tx, 1'b1);
      @(negedge clk);
      pi_flag = 1'b1;
      pi_data = 8'hB9;
      exp_q.push_back(8'hB9);
      @(posedge clk); #1;
      check("push_pop_full_no_ovf", tx_ovf, 1'b0);
      check("push_pop_full_stays_full", fifo_full, 1'b1);
      check("back_to_back_start", tx, 1'b0);
      @(negedge clk);
      pi_flag = 1'b0;
      @(posedge clk); #1;
      check("push_pop_full_no_ovf_late", tx_ovf, 1'b0);
      check("push_pop_full_count_held", fifo_full, 1'b1);
      wait_idle(12 * FRAME);

      // Reset in the middle of a data bit of the second frame of a burst.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pi_flag = 1'b1;
         pi_data = 8'(8'hC0 + i);
         exp_q.push_back(8'(8'hC0 + i));
         @(posedge clk);
      end
      @(negedge clk);
      pi_flag = 1'b0;
      repeat (FRAME + 2 * C + 20 - 2) @(posedge clk);
      #1;
      check("tx_low_in_data_bit1", tx, 1'b0);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_full", fifo_full, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      bad = 0;
      repeat (2 * FRAME) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("no_frames_after_reset", bad, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
